// File: rtl/can_id_capture_filter.sv
// can_id_capture_filter: serial CAN identifier capture (base/ext ID, RTR/IDE)
// followed by code/mask acceptance filtering with lowest-index priority.
module can_id_capture_filter #(
  parameter int NUM_FILT = 4,
  parameter int EXT_EN   = 1,
  parameter int IDX_W    = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sp_en_i,
  input  logic                  rx_bit_i,
  input  logic                  sof_i,
  input  logic                  abort_i,
  input  logic [29*NUM_FILT-1:0] filt_code_i,
  input  logic [29*NUM_FILT-1:0] filt_mask_i,
  input  logic [NUM_FILT-1:0]   filt_ide_i,
  input  logic [NUM_FILT-1:0]   filt_en_i,
  output logic [28:0]           id_o,
  output logic                  ide_o,
  output logic                  rtr_o,
  output logic                  id_valid_o,
  output logic                  match_o,
  output logic [IDX_W-1:0]      match_idx_o,
  output logic                  busy_o,
  output logic                  frame_err_o
);
  typedef enum logic [2:0] {IDLE, BASE, SRR_RTR, IDE, EXT, RTR_X, FILT, DONE} state_t;
  state_t state, nxt;
  logic [4:0] cnt;
  logic [10:0] base_r;
  logic [17:0] ext_r;
  logic tmp_rtr, rtr_w, ide_w, restart, go;
  logic [28:0] id_w;
  logic [NUM_FILT-1:0] hit;
  logic [IDX_W-1:0] idx;
  // sof restarts capture anywhere except the two closing single-cycle states
  assign restart = sof_i & ~abort_i & (state != FILT) & (state != DONE);
  assign go = sp_en_i & ~abort_i & ~sof_i;
  assign id_w = {ide_w ? ext_r : 18'h0, base_r};
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    if (abort_i) nxt = IDLE;
    else if (restart) nxt = BASE;
    else
      case (state)
        BASE:    nxt = (go && cnt == 5'd10) ? SRR_RTR : BASE;
        SRR_RTR: nxt = go ? IDE : SRR_RTR;
        IDE:     nxt = !go ? IDE : !rx_bit_i ? FILT : (EXT_EN != 0) ? EXT : IDLE;
        EXT:     nxt = (go && cnt == 5'd17) ? RTR_X : EXT;
        RTR_X:   nxt = go ? FILT : RTR_X;
        FILT:    nxt = DONE;
        default: nxt = IDLE;
      endcase
  end
  always_comb begin
    busy_o = state != IDLE;
    hit = '0;
    idx = '0;
    for (int k = 0; k < NUM_FILT; k++)
      hit[k] = filt_en_i[k] & (ide_w == filt_ide_i[k]) &
               ~|((id_w ^ filt_code_i[29*k +: 29]) & filt_mask_i[29*k +: 29]);
    for (int k = NUM_FILT - 1; k >= 0; k--)
      if (hit[k]) idx = IDX_W'(k);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt <= '0;
      base_r <= '0;
      ext_r <= '0;
      tmp_rtr <= 1'b0;
      rtr_w <= 1'b0;
      ide_w <= 1'b0;
      id_o <= '0;
      ide_o <= 1'b0;
      rtr_o <= 1'b0;
      match_o <= 1'b0;
      match_idx_o <= '0;
      id_valid_o <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      id_valid_o <= (state == FILT) & ~abort_i;
      frame_err_o <= (state == IDE) & go & rx_bit_i & (EXT_EN == 0);
      if (restart) cnt <= '0;
      else if (go && (state == BASE || state == EXT))
        cnt <= (state == BASE && cnt == 5'd10) ? '0 : cnt + 5'd1;
      if (go && state == BASE) base_r <= {base_r[9:0], rx_bit_i};
      if (go && state == EXT) ext_r <= {ext_r[16:0], rx_bit_i};
      if (go && state == SRR_RTR) tmp_rtr <= rx_bit_i;
      if (go && state == IDE) begin
        ide_w <= rx_bit_i;
        if (!rx_bit_i) rtr_w <= tmp_rtr;
      end
      if (go && state == RTR_X) rtr_w <= rx_bit_i;
      // results land at the FILT->DONE edge so id_valid_o and the data appear together
      if (state == FILT && !abort_i) begin
        id_o <= id_w;
        ide_o <= ide_w;
        rtr_o <= rtr_w;
        match_o <= |hit;
        match_idx_o <= idx;
      end
    end
endmodule

// File: tb/tb_can_id_capture_filter.sv
// tb_can_id_capture_filter: directed frames with a scoreboard of expected results;
// a second instance built with EXT_EN=0 checks the frame error path.
module tb_can_id_capture_filter;
  localparam int NF = 4;
  logic clk = 0, reset_n = 0, sp_en_i = 0, rx_bit_i = 0, sof_i = 0, abort_i = 0;
  logic [29*NF-1:0] code = '0, mask = '0;
  logic [NF-1:0] fide = '0, fen = '0;
  logic [28:0] id_o, id_n;
  logic ide_o, rtr_o, id_valid_o, match_o, busy_o, frame_err_o;
  logic ide_n, rtr_n, valid_n, match_n, busy_n, frame_err_n;
  logic [1:0] match_idx_o, idx_n;
  typedef struct {
    logic [28:0] id;
    logic ide;
    logic rtr;
    logic m;
    logic [1:0] idx;
    int cyc;
  } exp_t;
  exp_t q[$];
  int errs = 0, checks = 0, cyc = 0, std_done = 0, v_n = 0;
  can_id_capture_filter #(.NUM_FILT(NF), .EXT_EN(1)) dut (
    .clk(clk), .reset_n(reset_n), .sp_en_i(sp_en_i), .rx_bit_i(rx_bit_i), .sof_i(sof_i),
    .abort_i(abort_i), .filt_code_i(code), .filt_mask_i(mask), .filt_ide_i(fide),
    .filt_en_i(fen), .id_o(id_o), .ide_o(ide_o), .rtr_o(rtr_o), .id_valid_o(id_valid_o),
    .match_o(match_o), .match_idx_o(match_idx_o), .busy_o(busy_o), .frame_err_o(frame_err_o));
  can_id_capture_filter #(.NUM_FILT(NF), .EXT_EN(0)) dut_n (
    .clk(clk), .reset_n(reset_n), .sp_en_i(sp_en_i), .rx_bit_i(rx_bit_i), .sof_i(sof_i),
    .abort_i(abort_i), .filt_code_i(code), .filt_mask_i(mask), .filt_ide_i(fide),
    .filt_en_i(fen), .id_o(id_n), .ide_o(ide_n), .rtr_o(rtr_n), .id_valid_o(valid_n),
    .match_o(match_n), .match_idx_o(idx_n), .busy_o(busy_n), .frame_err_o(frame_err_n));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  function automatic exp_t mk(input logic [28:0] id, input logic ide, input logic rtr,
                              input logic m, input logic [1:0] idx);
    mk.id = id;
    mk.ide = ide;
    mk.rtr = rtr;
    mk.m = m;
    mk.idx = idx;
    mk.cyc = 0;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (valid_n) v_n++;
    if (frame_err_o) chk("ferr_with_ext_en", 32'(frame_err_o), 0);
    if (id_valid_o) begin
      if (q.size() == 0) chk("unexpected_valid", 32'(id_valid_o), 0);
      else begin
        e = q.pop_front();
        chk("id", 32'(id_o), 32'(e.id));
        chk("ide", 32'(ide_o), 32'(e.ide));
        chk("rtr", 32'(rtr_o), 32'(e.rtr));
        chk("match", 32'(match_o), 32'(e.m));
        chk("match_idx", 32'(match_idx_o), 32'(e.idx));
        chk("latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end
  task automatic chk_zero(input string p);
    chk({p, "_id"}, 32'(id_o), 0);
    chk({p, "_ide"}, 32'(ide_o), 0);
    chk({p, "_rtr"}, 32'(rtr_o), 0);
    chk({p, "_match"}, 32'(match_o), 0);
    chk({p, "_idx"}, 32'(match_idx_o), 0);
    chk({p, "_valid"}, 32'(id_valid_o), 0);
    chk({p, "_busy"}, 32'(busy_o), 0);
  endtask
  // kind: 0 complete, 1 abort after stop_at bits, 2 stop silently, 3 async reset after stop_at bits
  task automatic frame(input logic [31:0] v, input int n, input int stop_at, input int kind,
                       input exp_t e);
    @(negedge clk);
    sof_i = 1; sp_en_i = 1; rx_bit_i = 0;
    @(negedge clk);
    sof_i = 0; sp_en_i = 0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      sp_en_i = 1; rx_bit_i = v[n-1-i];
      @(negedge clk);
      sp_en_i = 0;
      if (n == 32 && i == 12) chk("ferr_pulse_ext_en0", 32'(frame_err_n), 1);
      if (i == n - 1 && kind == 0) begin
        e.cyc = cyc + 1;
        q.push_back(e);
        if (n == 13) std_done++;
      end
      if (i + 1 == stop_at) begin
        if (kind == 1) begin
          abort_i = 1;
          @(negedge clk);
          abort_i = 0;
          chk("busy_after_abort", 32'(busy_o), 0);
        end else if (kind == 3) begin
          #2 reset_n = 0;
          #1 chk_zero("async_reset");
          @(negedge clk);
          reset_n = 1;
        end
        return;
      end
      @(negedge clk);
    end
  endtask
  localparam logic [31:0] T1 = 32'({11'h123, 2'b00});
  localparam logic [31:0] T2 = {11'h4A5, 1'b1, 1'b1, 18'h2B3C1, 1'b1};
  localparam logic [28:0] T2_ID = {18'h2B3C1, 11'h4A5};
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset_n = 1;
    code[28:0] = 29'h123; mask[28:0] = 29'h7FF; fide = 4'b0000; fen = 4'b0001;
    frame(T1, 13, 0, 0, mk(29'h123, 0, 0, 1, 0));
    frame(32'({11'h124, 2'b00}), 13, 0, 0, mk(29'h124, 0, 0, 0, 0));
    frame(32'({11'h123, 2'b10}), 13, 0, 0, mk(29'h123, 0, 1, 1, 0));
    mask[28:0] = 29'h7F0;
    frame(32'({11'h12F, 2'b00}), 13, 0, 0, mk(29'h12F, 0, 0, 1, 0));
    mask[28:0] = 29'h7FF;
    frame(T2, 32, 0, 0, mk(T2_ID, 1, 1, 0, 0));
    code[87:58] = 29'h1FFFFFFF; mask[28:0] = '0; mask[86:58] = 29'h1FFFFFFF;
    fide = 4'b1111; fen = 4'b1110;
    frame(T2, 32, 0, 0, mk(T2_ID, 1, 1, 1, 1));
    fen = 4'b1000;
    frame(T2, 32, 0, 0, mk(T2_ID, 1, 1, 1, 3));
    fen = 4'b0000;
    frame(T2, 32, 0, 0, mk(T2_ID, 1, 1, 0, 0));
    frame(T2, 32, 20, 1, mk(0, 0, 0, 0, 0));
    chk("hold_id_after_abort", 32'(id_o), 32'(T2_ID));
    chk("hold_ide_after_abort", 32'(ide_o), 1);
    mask[28:0] = 29'h7FF; fide = 4'b1110; fen = 4'b0001;
    frame(T1, 13, 0, 0, mk(29'h123, 0, 0, 1, 0));
    frame(T2, 32, 8, 2, mk(0, 0, 0, 0, 0));
    frame(T1, 13, 0, 0, mk(29'h123, 0, 0, 1, 0));
    frame(T2, 32, 15, 3, mk(0, 0, 0, 0, 0));
    frame(T1, 13, 0, 0, mk(29'h123, 0, 0, 1, 0));
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 32'(q.size()), 0);
    chk("ext_en0_valid_count", 32'(v_n), 32'(std_done));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
